shared_mem_arbiter: RTL
=======================

# shared_mem_arbiter

Shared-memory responder for the multi-core processor: serves word read/write requests from NUM_CORES cores against one internal MEM_SIZE x MEM_WIDTH array, one access at a time. It sits below the core array inside the processor top and is the memory side of the per-core `mem_addr`/`mem_read_en`/`mem_write_en`/`mem_read_val`/`mem_write_val` data port. It adds a ready handshake so cores stall while another core owns the memory.

## Interface
- MEM_WIDTH, 32, data word width in bits
- MEM_SIZE, 256, number of words in the array; power of two
- NUM_CORES, 2, number of requesting cores, 1..8
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-low reset
- req_addr  input  NUM_CORES*32  byte address per core; slice i = [32*i+31:32*i]
- req_read_en  input  NUM_CORES  per-core read request
- req_write_en  input  NUM_CORES  per-core write request
- req_write_val  input  NUM_CORES*MEM_WIDTH  per-core write data
- resp_ready  output  NUM_CORES  one-cycle completion pulse per core
- resp_read_val  output  NUM_CORES*MEM_WIDTH  per-core read data, held until that core's next completion

## Operation
- Core i requests when req_read_en[i] or req_write_en[i] is high; holds addr/data/enables stable until resp_ready[i].
- Word index = addr[log2(MEM_SIZE)+1:2]; addr[1:0] and bits above the index are ignored (address wraps modulo MEM_SIZE words).
- FSM states: IDLE, ACCESS, RESP.
  - IDLE: if any request, select winner g, latch g, index, write data, op; go to ACCESS. Else stay.
  - ACCESS: perform the access; read captures mem[index] into resp_read_val slice g; write stores data; go to RESP.
  - RESP: resp_ready[g]=1 for exactly this cycle; go to IDLE.
- read_en and write_en both high: write performed; read_val returns the old contents (read-before-write).
- Only the granted core's read_val slice changes; other slices hold.
- Requests arriving in ACCESS/RESP are not sampled until the next IDLE.
- Memory contents are not reset.

## Timing
- Reset (reset=0): state IDLE, resp_ready all 0, resp_read_val all 0, arbitration pointer = NUM_CORES-1 (core 0 wins first). Reset asserted during ACCESS aborts; no write occurs if reset is low at the ACCESS edge.
- Latency: request sampled at edge E0 -> ACCESS after E0 -> access at E1 -> resp_ready[g] high from E1 to E2. Read data valid when resp_ready rises.
- Throughput: one access per 3 cycles.
- Core must drop its request before E2; a request still high at E2 (in IDLE) is a new request.
- Simultaneous requests: one grant per IDLE; losers keep requesting and are served in later rounds.

## Configuration
- RR_ARB_EN defined: round-robin; search starts at pointer+1, pointer updates to g on every grant; no core waits more than NUM_CORES grants.
- RR_ARB_EN undefined: fixed priority, lowest index wins; pointer unused.

## Structure
- defines.v holds: FSM state encodings (IDLE/ACCESS/RESP), ADDR_LSB=2, log2 helper macro for index width.
- One sub-module: rr_arbiter (request vector + pointer -> one-hot grant and index), honouring RR_ARB_EN.
- Memory array inline in shared_mem_arbiter.

## Test plan
- Reset then core 0 writes 0xDEADBEEF to addr 0x10, then reads 0x10 -> resp_ready[0] 2 cycles after each sampled request; read_val[0]=0xDEADBEEF.
- Cores 0 and 1 request together (write 0x11 to addr 0x4, write 0x22 to addr 0x8) -> core 0 completes first, core 1 three cycles later; reads return 0x11 and 0x22.
- Both cores hold requests continuously, RR_ARB_EN defined -> grants alternate 0,1,0,1; undefined -> core 0 every grant, core 1 starved.
- Write 0xA5 to addr 0x400 (MEM_SIZE=256) -> read of addr 0x0 returns 0xA5 (wrap).
- Read+write same cycle to addr 0x20 holding 0x5, write 0x7 -> read_val=0x5, subsequent read=0x7.
- reset low during ACCESS of a write to addr 0x30 -> no resp_ready, outputs zero, addr 0x30 retains previous value.

Source files
------------

// File: rtl/shared_mem_arbiter_pkg.sv
// Shared-memory arbiter package: FSM state encodings, address constants and
// an index-width helper shared by the top and the arbiter sub-module.
package shared_mem_arbiter_pkg;

   // state      | meaning
   // ST_IDLE    | waiting for a request; winner is latched on the grant edge
   // ST_ACCESS  | memory read/write of the latched request happens this cycle
   // ST_RESP    | resp_ready high for the granted core, then back to IDLE
   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ACCESS = 2'd1,
      ST_RESP   = 2'd2
   } state_t;

   localparam int ADDR_LSB   = 2;
   localparam int REQ_ADDR_W = 32;

   // Width needed to index n items; never less than one bit.
   function automatic int idx_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/shared_mem_arbiter_rr_arbiter.sv
// Grant selection for shared_mem_arbiter.
// Build option: RR_ARB_EN selects round-robin (search starts after i_ptr);
// without it, fixed priority with the lowest index winning.
// Ports:
//   i_req       per-core request vector
//   i_ptr       index of the last granted core (round-robin only)
//   o_grant     one-hot grant
//   o_grant_idx binary index of the granted core
//   o_valid     at least one request present
module shared_mem_arbiter_rr_arbiter
   import shared_mem_arbiter_pkg::*;
#(
   parameter int NUM_CORES = 2,
   parameter int IDX_W     = 1
) (
   input  logic [NUM_CORES-1:0] i_req,
   input  logic [IDX_W-1:0]     i_ptr,
   output logic [NUM_CORES-1:0] o_grant,
   output logic [IDX_W-1:0]     o_grant_idx,
   output logic                 o_valid
);

   logic [IDX_W-1:0] w_idx;
   logic             w_found;

`ifdef RR_ARB_EN
   // Doubled request vector: scanning positions ptr+1 .. ptr+NUM_CORES visits
   // every core exactly once, starting just after the previous winner.
   logic [2*NUM_CORES-1:0] w_req2;

   always_comb begin
      w_req2  = {i_req, i_req};
      w_idx   = '0;
      w_found = 1'b0;
      for (int k = 0; k < 2*NUM_CORES; k++) begin
         if (!w_found && (k > int'(i_ptr)) && w_req2[k]) begin
            w_found = 1'b1;
            w_idx   = IDX_W'(k % NUM_CORES);
         end
      end
   end
`else
   logic w_unused_ptr;
   assign w_unused_ptr = ^i_ptr;

   always_comb begin
      w_idx   = '0;
      w_found = 1'b0;
      for (int k = 0; k < NUM_CORES; k++) begin
         if (!w_found && i_req[k]) begin
            w_found = 1'b1;
            w_idx   = IDX_W'(k);
         end
      end
   end
`endif

   always_comb begin
      o_grant = '0;
      for (int j = 0; j < NUM_CORES; j++) begin
         o_grant[j] = w_found && (w_idx == IDX_W'(j));
      end
   end

   assign o_grant_idx = w_idx;
   assign o_valid     = w_found;

endmodule

// File: rtl/shared_mem_arbiter.sv
// Shared-memory responder: serves word reads/writes from NUM_CORES cores
// against one internal MEM_SIZE x MEM_WIDTH array, one access per 3 cycles.
// Build option: RR_ARB_EN (round-robin grant; default fixed priority).
// Ports:
//   clk, reset      rising-edge clock, async active-low reset
//   req_addr        per-core byte address, 32 bits per core
//   req_read_en     per-core read request
//   req_write_en    per-core write request (both high: read-before-write)
//   req_write_val   per-core write data
//   resp_ready      one-cycle completion pulse per core
//   resp_read_val   per-core read data, held until that core's next read
module shared_mem_arbiter
   import shared_mem_arbiter_pkg::*;
#(
   parameter int MEM_WIDTH = 32,
   parameter int MEM_SIZE  = 256,
   parameter int NUM_CORES = 2
) (
   input  logic                           clk,
   input  logic                           reset,
   input  logic [NUM_CORES*REQ_ADDR_W-1:0] req_addr,
   input  logic [NUM_CORES-1:0]           req_read_en,
   input  logic [NUM_CORES-1:0]           req_write_en,
   input  logic [NUM_CORES*MEM_WIDTH-1:0] req_write_val,
   output logic [NUM_CORES-1:0]           resp_ready,
   output logic [NUM_CORES*MEM_WIDTH-1:0] resp_read_val
);

   localparam int IDX_W = idx_width(NUM_CORES);
   localparam int AW    = idx_width(MEM_SIZE);

   state_t                         r_state, w_next_state;
   logic [IDX_W-1:0]               r_ptr, r_gidx, w_win_idx;
   logic [NUM_CORES-1:0]           w_req, w_win_onehot;
   logic                           w_win_valid;
   logic [AW-1:0]                  r_index, w_sel_index;
   logic [MEM_WIDTH-1:0]           r_wdata, w_sel_wdata;
   logic                           r_rd, r_wr, w_sel_rd, w_sel_wr;
   logic [MEM_WIDTH-1:0]           r_mem [MEM_SIZE];
   logic [NUM_CORES*MEM_WIDTH-1:0] r_read_val;

   // Byte offset and address bits above the word index are don't-care.
   logic w_unused_addr;
   assign w_unused_addr = ^req_addr;

   assign w_req = req_read_en | req_write_en;

   shared_mem_arbiter_rr_arbiter #(
      .NUM_CORES (NUM_CORES),
      .IDX_W     (IDX_W)
   ) u_arb (
      .i_req       (w_req),
      .i_ptr       (r_ptr),
      .o_grant     (w_win_onehot),
      .o_grant_idx (w_win_idx),
      .o_valid     (w_win_valid)
   );

   always_comb begin
      w_sel_index = '0;
      w_sel_wdata = '0;
      w_sel_rd    = 1'b0;
      w_sel_wr    = 1'b0;
      for (int j = 0; j < NUM_CORES; j++) begin
         if (w_win_onehot[j]) begin
            w_sel_index = req_addr[REQ_ADDR_W*j + ADDR_LSB +: AW];
            w_sel_wdata = req_write_val[MEM_WIDTH*j +: MEM_WIDTH];
            w_sel_rd    = req_read_en[j];
            w_sel_wr    = req_write_en[j];
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) r_state <= ST_IDLE;
      else        r_state <= w_next_state;
   end

   always_comb begin
      w_next_state = r_state;
      case (r_state)
         ST_IDLE:   if (w_win_valid) w_next_state = ST_ACCESS;
         ST_ACCESS: w_next_state = ST_RESP;
         ST_RESP:   w_next_state = ST_IDLE;
         default:   w_next_state = ST_IDLE;
      endcase
   end

   always_comb begin
      resp_ready = '0;
      for (int j = 0; j < NUM_CORES; j++) begin
         resp_ready[j] = (r_state == ST_RESP) && (r_gidx == IDX_W'(j));
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_ptr      <= IDX_W'(NUM_CORES-1);
         r_gidx     <= '0;
         r_index    <= '0;
         r_wdata    <= '0;
         r_rd       <= 1'b0;
         r_wr       <= 1'b0;
         r_read_val <= '0;
      end else begin
         if (r_state == ST_IDLE && w_win_valid) begin
            r_gidx  <= w_win_idx;
            r_ptr   <= w_win_idx;
            r_index <= w_sel_index;
            r_wdata <= w_sel_wdata;
            r_rd    <= w_sel_rd;
            r_wr    <= w_sel_wr;
         end
         // Nonblocking read of r_mem sees the pre-write word: read-before-write.
         if (r_state == ST_ACCESS && r_rd) begin
            for (int j = 0; j < NUM_CORES; j++) begin
               if (r_gidx == IDX_W'(j))
                  r_read_val[MEM_WIDTH*j +: MEM_WIDTH] <= r_mem[r_index];
            end
         end
      end
   end

   // Array is intentionally not reset; a low reset blocks the pending write.
   always_ff @(posedge clk) begin
      if (reset && r_state == ST_ACCESS && r_wr)
         r_mem[r_index] <= r_wdata;
   end

   assign resp_read_val = r_read_val;

endmodule
